// File: rtl/bp_pkg.sv
// Prediction metadata record and default widths shared by the branch resolve unit.
package bp_pkg;
  localparam int PHT_ADDRESS = 9;
  localparam int GHR_SIZE    = 9;
  localparam int XLEN        = 32;
  localparam int RAS_ADDRESS = 3;
  localparam int DEPTH       = 8;
  localparam int TAG_W       = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        pred_target;
    logic                   pred_taken;
    logic                   btb_hit;
    logic                   is_branch;
    logic                   is_call;
    logic                   is_ret;
    logic [PHT_ADDRESS-1:0] pht_index;
    logic [GHR_SIZE-1:0]    prev_ghr;
    logic [RAS_ADDRESS-1:0] sp_snap;
    logic [2*XLEN-1:0]      ras_snap;
  } bp_meta_t;

  // True when tag is strictly younger than ref_tag, ages measured from head.
  function automatic logic is_younger(input logic [TAG_W-1:0] tag,
                                      input logic [TAG_W-1:0] ref_tag,
                                      input logic [TAG_W-1:0] head);
    logic [TAG_W-1:0] age_tag;
    logic [TAG_W-1:0] age_ref;
    age_tag = tag - head;
    age_ref = ref_tag - head;
    return age_tag > age_ref;
  endfunction
endpackage

// File: rtl/branch_resolve_unit.sv
// In-order queue of branch prediction metadata; resolves outcomes out of order,
// drives predictor update/restore strobes and flushes younger entries on a mispredict.
module branch_resolve_unit #(
  parameter int PHT_ADDRESS = bp_pkg::PHT_ADDRESS,
  parameter int GHR_SIZE    = bp_pkg::GHR_SIZE,
  parameter int XLEN        = bp_pkg::XLEN,
  parameter int RAS_ADDRESS = bp_pkg::RAS_ADDRESS,
  parameter int DEPTH       = bp_pkg::DEPTH,
  localparam int TAG_W      = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  output logic [TAG_W-1:0]       alloc_tag_o,
  input  logic [XLEN-1:0]        alloc_pc_i,
  input  logic [XLEN-1:0]        alloc_pred_target_i,
  input  logic                   alloc_pred_taken_i,
  input  logic                   alloc_btb_hit_i,
  input  logic                   alloc_is_branch_i,
  input  logic                   alloc_is_call_i,
  input  logic                   alloc_is_ret_i,
  input  logic [PHT_ADDRESS-1:0] alloc_pht_index_i,
  input  logic [GHR_SIZE-1:0]    alloc_prev_ghr_i,
  input  logic [RAS_ADDRESS-1:0] alloc_sp_snap_i,
  input  logic [2*XLEN-1:0]      alloc_ras_snap_i,
  input  logic                   resolve_valid_i,
  input  logic [TAG_W-1:0]       resolve_tag_i,
  input  logic                   resolve_taken_i,
  input  logic [XLEN-1:0]        resolve_target_i,
  output logic                   actual_taken_o,
  output logic                   mispredict_o,
  output logic                   restore_ghr_o,
  output logic                   restore_ras_o,
  output logic                   update_pht_o,
  output logic                   update_btb_o,
  output logic                   update_ras_o,
  output logic                   ex_is_ret_o,
  output logic                   ex_is_branch_o,
  output logic [XLEN-1:0]        actual_target_address_o,
  output logic [XLEN-1:0]        actual_return_address_o,
  output logic [XLEN-1:0]        ex_pc_o,
  output logic [GHR_SIZE-1:0]    ghr_snap_o,
  output logic [PHT_ADDRESS-1:0] rb_pht_index_o,
  output logic [RAS_ADDRESS-1:0] rb_sp_snap_o,
  output logic [2*XLEN-1:0]      rb_ras_snap_o,
  output logic                   redirect_valid_o,
  output logic [XLEN-1:0]        redirect_pc_o
);
  import bp_pkg::*;

  localparam int PTR_W = TAG_W + 1;

  bp_meta_t               meta_q [DEPTH];
  bp_meta_t               alloc_meta;
  bp_meta_t               res_meta;
  logic [DEPTH-1:0]       valid_q, valid_d, resolved_q, resolved_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, res_ptr;
  logic [TAG_W-1:0]       head_tag, tail_tag, res_age;
  logic                   full, alloc_fire, res_accept, res_mis, flush, retire;
  logic [XLEN-1:0]        link_addr;

  logic                   taken_q, taken_d, mis_q, mis_d, upd_pht_q, upd_pht_d;
  logic                   upd_btb_q, upd_btb_d, upd_ras_q, upd_ras_d;
  logic                   is_ret_q, is_ret_d, is_br_q, is_br_d;
  logic [XLEN-1:0]        tgt_q, tgt_d, ret_q, ret_d, pc_q, pc_d, redir_q, redir_d;
  logic [GHR_SIZE-1:0]    ghr_q, ghr_d;
  logic [PHT_ADDRESS-1:0] pht_q, pht_d;
  logic [RAS_ADDRESS-1:0] sp_q, sp_d;
  logic [2*XLEN-1:0]      ras_q, ras_d;

  assign head_tag   = head_q[TAG_W-1:0];
  assign tail_tag   = tail_q[TAG_W-1:0];
  assign full       = (head_tag == tail_tag) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign alloc_fire = alloc_valid_i && !full;
  assign res_meta   = meta_q[resolve_tag_i];
  assign res_accept = resolve_valid_i && valid_q[resolve_tag_i] && !resolved_q[resolve_tag_i];
  assign res_mis    = (resolve_taken_i != res_meta.pred_taken) |
                      (resolve_taken_i & (resolve_target_i != res_meta.pred_target));
  assign flush      = res_accept && res_mis;
  assign retire     = valid_q[head_tag] && resolved_q[head_tag];
  assign link_addr  = res_meta.pc + XLEN'(4);
  // Full-width pointer of the resolving entry, so the new tail keeps a correct wrap bit.
  assign res_age    = resolve_tag_i - head_tag;
  assign res_ptr    = head_q + {1'b0, res_age};

  always_comb begin
    alloc_meta             = '0;
    alloc_meta.pc          = alloc_pc_i;
    alloc_meta.pred_target = alloc_pred_target_i;
    alloc_meta.pred_taken  = alloc_pred_taken_i;
    alloc_meta.btb_hit     = alloc_btb_hit_i;
    alloc_meta.is_branch   = alloc_is_branch_i;
    alloc_meta.is_call     = alloc_is_call_i;
    alloc_meta.is_ret      = alloc_is_ret_i;
    alloc_meta.pht_index   = alloc_pht_index_i;
    alloc_meta.prev_ghr    = alloc_prev_ghr_i;
    alloc_meta.sp_snap     = alloc_sp_snap_i;
    alloc_meta.ras_snap    = alloc_ras_snap_i;
  end

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (retire) begin
      valid_d[head_tag]    = 1'b0;
      resolved_d[head_tag] = 1'b0;
      head_d               = head_q + PTR_W'(1);
    end
    if (res_accept) resolved_d[resolve_tag_i] = 1'b1;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (is_younger(TAG_W'(i), resolve_tag_i, head_tag)) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      tail_d = res_ptr + PTR_W'(1);
    end else if (alloc_fire) begin
      valid_d[tail_tag]    = 1'b1;
      resolved_d[tail_tag] = 1'b0;
      tail_d               = tail_q + PTR_W'(1);
    end
  end

  always_comb begin
    taken_d   = 1'b0;
    mis_d     = 1'b0;
    upd_pht_d = 1'b0;
    upd_btb_d = 1'b0;
    upd_ras_d = 1'b0;
    is_ret_d  = 1'b0;
    is_br_d   = 1'b0;
    tgt_d     = tgt_q;
    ret_d     = ret_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    ghr_d     = ghr_q;
    pht_d     = pht_q;
    sp_d      = sp_q;
    ras_d     = ras_q;
    if (res_accept) begin
      taken_d   = resolve_taken_i;
      mis_d     = res_mis;
      upd_pht_d = res_meta.is_branch;
      upd_btb_d = resolve_taken_i &
                  (~res_meta.btb_hit | (resolve_target_i != res_meta.pred_target));
      upd_ras_d = res_mis & res_meta.is_call;
      is_ret_d  = res_meta.is_ret;
      is_br_d   = res_meta.is_branch;
      tgt_d     = resolve_target_i;
      ret_d     = link_addr;
      pc_d      = res_meta.pc;
      redir_d   = resolve_taken_i ? resolve_target_i : link_addr;
      ghr_d     = res_meta.is_branch ?
                  {res_meta.prev_ghr[GHR_SIZE-2:0], resolve_taken_i} : res_meta.prev_ghr;
      pht_d     = res_meta.pht_index;
      sp_d      = res_meta.sp_snap;
      ras_d     = res_meta.ras_snap;
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_fire && !flush) meta_q[tail_tag] <= alloc_meta;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      taken_q    <= 1'b0;
      mis_q      <= 1'b0;
      upd_pht_q  <= 1'b0;
      upd_btb_q  <= 1'b0;
      upd_ras_q  <= 1'b0;
      is_ret_q   <= 1'b0;
      is_br_q    <= 1'b0;
      tgt_q      <= '0;
      ret_q      <= '0;
      pc_q       <= '0;
      redir_q    <= '0;
      ghr_q      <= '0;
      pht_q      <= '0;
      sp_q       <= '0;
      ras_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      taken_q    <= taken_d;
      mis_q      <= mis_d;
      upd_pht_q  <= upd_pht_d;
      upd_btb_q  <= upd_btb_d;
      upd_ras_q  <= upd_ras_d;
      is_ret_q   <= is_ret_d;
      is_br_q    <= is_br_d;
      tgt_q      <= tgt_d;
      ret_q      <= ret_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      ghr_q      <= ghr_d;
      pht_q      <= pht_d;
      sp_q       <= sp_d;
      ras_q      <= ras_d;
    end
  end

  assign alloc_ready_o = !full;
  assign alloc_tag_o   = tail_tag;

  // A strobe registered just before reset rises must not reach the front end.
  assign actual_taken_o   = taken_q & ~reset_i;
  assign mispredict_o     = mis_q & ~reset_i;
  assign redirect_valid_o = mis_q & ~reset_i;
  assign restore_ghr_o    = mis_q & ~reset_i;
  assign restore_ras_o    = mis_q & ~reset_i;
  assign update_pht_o     = upd_pht_q & ~reset_i;
  assign update_btb_o     = upd_btb_q & ~reset_i;
  assign update_ras_o     = upd_ras_q & ~reset_i;
  assign ex_is_ret_o      = is_ret_q & ~reset_i;
  assign ex_is_branch_o   = is_br_q & ~reset_i;

  assign actual_target_address_o = tgt_q;
  assign actual_return_address_o = ret_q;
  assign ex_pc_o                 = pc_q;
  assign redirect_pc_o           = redir_q;
  assign ghr_snap_o              = ghr_q;
  assign rb_pht_index_o          = pht_q;
  assign rb_sp_snap_o            = sp_q;
  assign rb_ras_snap_o           = ras_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for resolve outcomes plus
// hand-written flush, full/wrap, out-of-order retire and reset sequences.
module tb_branch_resolve_unit;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alloc_valid_i, alloc_ready_o;
  logic [2:0]  alloc_tag_o;
  logic [31:0] alloc_pc_i, alloc_pred_target_i;
  logic        alloc_pred_taken_i, alloc_btb_hit_i, alloc_is_branch_i, alloc_is_call_i, alloc_is_ret_i;
  logic [8:0]  alloc_pht_index_i, alloc_prev_ghr_i;
  logic [2:0]  alloc_sp_snap_i;
  logic [63:0] alloc_ras_snap_i;
  logic        resolve_valid_i;
  logic [2:0]  resolve_tag_i;
  logic        resolve_taken_i;
  logic [31:0] resolve_target_i;
  logic        actual_taken_o, mispredict_o, restore_ghr_o, restore_ras_o, update_pht_o;
  logic        update_btb_o, update_ras_o, ex_is_ret_o, ex_is_branch_o;
  logic [31:0] actual_target_address_o, actual_return_address_o, ex_pc_o;
  logic [8:0]  ghr_snap_o, rb_pht_index_o;
  logic [2:0]  rb_sp_snap_o;
  logic [63:0] rb_ras_snap_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  always #5 clk_i = ~clk_i;

  branch_resolve_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .alloc_pc_i(alloc_pc_i), .alloc_pred_target_i(alloc_pred_target_i),
    .alloc_pred_taken_i(alloc_pred_taken_i), .alloc_btb_hit_i(alloc_btb_hit_i),
    .alloc_is_branch_i(alloc_is_branch_i), .alloc_is_call_i(alloc_is_call_i),
    .alloc_is_ret_i(alloc_is_ret_i), .alloc_pht_index_i(alloc_pht_index_i),
    .alloc_prev_ghr_i(alloc_prev_ghr_i), .alloc_sp_snap_i(alloc_sp_snap_i),
    .alloc_ras_snap_i(alloc_ras_snap_i),
    .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .actual_taken_o(actual_taken_o), .mispredict_o(mispredict_o),
    .restore_ghr_o(restore_ghr_o), .restore_ras_o(restore_ras_o),
    .update_pht_o(update_pht_o), .update_btb_o(update_btb_o), .update_ras_o(update_ras_o),
    .ex_is_ret_o(ex_is_ret_o), .ex_is_branch_o(ex_is_branch_o),
    .actual_target_address_o(actual_target_address_o),
    .actual_return_address_o(actual_return_address_o), .ex_pc_o(ex_pc_o),
    .ghr_snap_o(ghr_snap_o), .rb_pht_index_o(rb_pht_index_o), .rb_sp_snap_o(rb_sp_snap_o),
    .rb_ras_snap_o(rb_ras_snap_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ptgt;
    logic        pt;
    logic        btb;
    logic        br;
    logic        call;
    logic        ret;
    logic [8:0]  ghr;
    logic        taken;
    logic [31:0] tgt;
    logic        e_mis;
    logic        e_ubtb;
    logic        e_uras;
    logic [8:0]  e_ghr;
    logic [31:0] e_redir;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs [8];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    alloc_valid_i = 1'b0;
    resolve_valid_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [31:0] ptgt, input logic pt,
                          input logic btb, input logic br, input logic call, input logic ret,
                          input logic [8:0] pht, input logic [8:0] ghr, input logic [2:0] sp,
                          input logic [63:0] ras);
    alloc_valid_i       = 1'b1;
    alloc_pc_i          = pc;
    alloc_pred_target_i = ptgt;
    alloc_pred_taken_i  = pt;
    alloc_btb_hit_i     = btb;
    alloc_is_branch_i   = br;
    alloc_is_call_i     = call;
    alloc_is_ret_i      = ret;
    alloc_pht_index_i   = pht;
    alloc_prev_ghr_i    = ghr;
    alloc_sp_snap_i     = sp;
    alloc_ras_snap_i    = ras;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic alloc_br(input logic [31:0] pc);
    do_alloc(pc, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 9'h0, 3'h0, 64'h0);
  endtask

  task automatic do_resolve(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
    resolve_valid_i  = 1'b1;
    resolve_tag_i    = tag;
    resolve_taken_i  = taken;
    resolve_target_i = tgt;
    tick();
    resolve_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int accepted;
    //          pc            ptgt          pt    btb   br    call  ret   ghr     tk    tgt           mis   ubtb  uras  e_ghr   e_redir       e_ret
    vecs[0] = '{32'h10,       32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0AA, 1'b1, 32'h8,        1'b1, 1'b1, 1'b0, 9'h155, 32'h8,        32'h14};
    vecs[1] = '{32'h10,       32'h8,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h123, 1'b1, 32'h8,        1'b0, 1'b0, 1'b0, 9'h123, 32'h8,        32'h14};
    vecs[2] = '{32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF, 1'b0, 32'h104,      1'b0, 1'b0, 1'b0, 9'h1FE, 32'h104,      32'h104};
    vecs[3] = '{32'h200,      32'h300,      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h001, 1'b0, 32'h300,      1'b1, 1'b0, 1'b0, 9'h002, 32'h204,      32'h204};
    vecs[4] = '{32'h400,      32'h500,      1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0F0, 1'b1, 32'h600,      1'b1, 1'b1, 1'b1, 9'h0F0, 32'h600,      32'h404};
    vecs[5] = '{32'h700,      32'h404,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h055, 1'b1, 32'h404,      1'b0, 1'b0, 1'b0, 9'h055, 32'h404,      32'h704};
    vecs[6] = '{32'hFFFFFFFC, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        32'h0};
    vecs[7] = '{32'h800,      32'h900,      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h080, 1'b1, 32'h900,      1'b0, 1'b0, 1'b0, 9'h101, 32'h900,      32'h804};

    reset_i = 1'b1; alloc_valid_i = 1'b0; resolve_valid_i = 1'b0;
    alloc_pc_i = '0; alloc_pred_target_i = '0; alloc_pred_taken_i = 1'b0; alloc_btb_hit_i = 1'b0;
    alloc_is_branch_i = 1'b0; alloc_is_call_i = 1'b0; alloc_is_ret_i = 1'b0;
    alloc_pht_index_i = '0; alloc_prev_ghr_i = '0; alloc_sp_snap_i = '0; alloc_ras_snap_i = '0;
    resolve_tag_i = '0; resolve_taken_i = 1'b0; resolve_target_i = '0;
    do_reset();

    chk("reset_alloc_ready", alloc_ready_o, 1);
    chk("reset_alloc_tag", alloc_tag_o, 0);
    chk("reset_strobes", {actual_taken_o, mispredict_o, restore_ghr_o, restore_ras_o, update_pht_o,
                          update_btb_o, update_ras_o, ex_is_ret_o, ex_is_branch_o, redirect_valid_o}, 0);
    chk("reset_data", {ex_pc_o, redirect_pc_o} | {actual_target_address_o, actual_return_address_o}, 0);
    chk("reset_snaps", {ghr_snap_o, rb_pht_index_o, rb_sp_snap_o} | rb_ras_snap_o, 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  tag;
      logic [8:0]  pht;
      logic [63:0] ras;
      tag = 3'(i);
      pht = 9'(i * 3 + 1);
      ras = {vecs[i].pc, ~vecs[i].ptgt};
      chk($sformatf("v%0d_alloc_tag", i), alloc_tag_o, tag);
      do_alloc(vecs[i].pc, vecs[i].ptgt, vecs[i].pt, vecs[i].btb, vecs[i].br, vecs[i].call,
               vecs[i].ret, pht, vecs[i].ghr, 3'(7 - i), ras);
      do_resolve(tag, vecs[i].taken, vecs[i].tgt);
      chk($sformatf("v%0d_mispredict", i), mispredict_o, vecs[i].e_mis);
      chk($sformatf("v%0d_redirect_valid", i), redirect_valid_o, vecs[i].e_mis);
      chk($sformatf("v%0d_restore", i), {restore_ghr_o, restore_ras_o}, {2{vecs[i].e_mis}});
      chk($sformatf("v%0d_update_btb", i), update_btb_o, vecs[i].e_ubtb);
      chk($sformatf("v%0d_update_ras", i), update_ras_o, vecs[i].e_uras);
      chk($sformatf("v%0d_update_pht", i), update_pht_o, vecs[i].br);
      chk($sformatf("v%0d_kind", i), {ex_is_branch_o, ex_is_ret_o}, {vecs[i].br, vecs[i].ret});
      chk($sformatf("v%0d_actual_taken", i), actual_taken_o, vecs[i].taken);
      chk($sformatf("v%0d_ghr_snap", i), ghr_snap_o, vecs[i].e_ghr);
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc_o, vecs[i].e_redir);
      chk($sformatf("v%0d_return_addr", i), actual_return_address_o, vecs[i].e_ret);
      chk($sformatf("v%0d_target", i), actual_target_address_o, vecs[i].tgt);
      chk($sformatf("v%0d_ex_pc", i), ex_pc_o, vecs[i].pc);
      chk($sformatf("v%0d_rb_snaps", i), {rb_pht_index_o, rb_sp_snap_o}, {pht, 3'(7 - i)});
      chk($sformatf("v%0d_rb_ras", i), rb_ras_snap_o, ras);
      tick();
      chk($sformatf("v%0d_strobe_drop", i), {mispredict_o, update_pht_o, actual_taken_o}, 0);
      chk($sformatf("v%0d_data_hold", i), ex_pc_o, vecs[i].pc);
    end

    // Flush of younger entries on a mispredict of tag 1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fl_alloc_tag%0d", k), alloc_tag_o, 3'(k));
      alloc_br(32'h1000 + 32'(4 * k));
    end
    do_resolve(3'd1, 1'b1, 32'h40);
    chk("fl_mispredict", mispredict_o, 1);
    chk("fl_redirect_pc", redirect_pc_o, 32'h40);
    chk("fl_tail", alloc_tag_o, 2);
    do_resolve(3'd3, 1'b1, 32'h80);
    chk("fl_dead_resolve", {mispredict_o, actual_taken_o, update_pht_o}, 0);
    chk("fl_dead_hold", ex_pc_o, 32'h1004);
    chk("fl_tail_hold", alloc_tag_o, 2);
    do_resolve(3'd0, 1'b0, 32'h0);
    chk("fl_tag0_ok", {update_pht_o, mispredict_o}, 2'b10);
    chk("fl_tag0_pc", ex_pc_o, 32'h1000);

    // Full queue, ignored alloc, wrap of the tail.
    do_reset();
    for (int k = 0; k < 8; k++) alloc_br(32'h2000 + 32'(4 * k));
    chk("full_ready", alloc_ready_o, 0);
    alloc_br(32'h2FFC);
    chk("full_ignored_ready", alloc_ready_o, 0);
    chk("full_ignored_tag", alloc_tag_o, 0);
    do_resolve(3'd0, 1'b0, 32'h0);
    chk("full_no_same_cycle_retire", alloc_ready_o, 0);
    tick();
    chk("full_retired_ready", alloc_ready_o, 1);
    chk("wrap_tag", alloc_tag_o, 0);
    alloc_br(32'h3000);
    chk("wrap_full_again", alloc_ready_o, 0);
    chk("wrap_tail_tag", alloc_tag_o, 1);
    do_resolve(3'd0, 1'b0, 32'h0);
    chk("wrap_new_entry_pc", ex_pc_o, 32'h3000);

    // Out-of-order resolves, in-order retirement.
    do_reset();
    for (int k = 0; k < 8; k++) alloc_br(32'h4000 + 32'(4 * k));
    do_resolve(3'd2, 1'b0, 32'h0);
    chk("ooo_pc2", ex_pc_o, 32'h4008);
    chk("ooo_hold_full2", alloc_ready_o, 0);
    do_resolve(3'd1, 1'b1, 32'h7000);
    chk("ooo_pc1", ex_pc_o, 32'h4004);
    chk("ooo_mis1", mispredict_o, 1);
    chk("ooo_tail_after_flush", alloc_tag_o, 2);
    do_resolve(3'd0, 1'b0, 32'h0);
    chk("ooo_pc0", ex_pc_o, 32'h4000);
    chk("ooo_no_same_cycle_retire", alloc_tag_o, 2);
    tick();
    tick();
    tick();
    accepted = 0;
    for (int k = 0; k < 12 && alloc_ready_o; k++) begin
      alloc_br(32'h5000);
      accepted++;
    end
    chk("ooo_free_slots", accepted, 8);
    chk("ooo_tail_wrapped", alloc_tag_o, 2);

    // Reset right after a mispredicting resolve suppresses its strobe.
    do_reset();
    alloc_br(32'h6000);
    do_resolve(3'd0, 1'b1, 32'h6100);
    reset_i = 1'b1;
    #1;
    chk("rst_no_mispredict", {mispredict_o, redirect_valid_o, restore_ghr_o, update_pht_o}, 0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("rst_alloc_tag", alloc_tag_o, 0);
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_data_clear", {ex_pc_o, redirect_pc_o}, 0);
    do_resolve(3'd0, 1'b1, 32'h6100);
    chk("rst_queue_empty", {mispredict_o, actual_taken_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
